aes_dec_round_iter: RTL and testbench

//  Iterative AES inverse-cipher datapath (FIPS-197 standard inverse cipher). Performs one

---
 rtl/aes_dec_round_iter.sv | 198 +++++++++++++++++++
 tb/tb_aes_dec_round_iter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_round_iter.sv
// aes_dec_round_iter: iterative AES-128/192/256 inverse cipher, one inverse round per clock.
// Optional feature: define AES_DEC_ABORT_EN to add i_Abort (cancel an in-flight block).
`default_nettype none

module aes_dec_round_iter #(
  parameter int DATA_W = 128,
  parameter int KIDX_W = 4
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [1:0]        i_Key_Mode,
  input  logic [DATA_W-1:0] i_Din,
  input  logic              i_Din_Valid,
  output logic              o_Din_Ready,
  output logic [KIDX_W-1:0] o_Key_Idx,
  input  logic [DATA_W-1:0] i_Round_Key,
  output logic [DATA_W-1:0] o_Dout,
  output logic              o_Dout_Valid,
  input  logic              i_Dout_Ready,
  output logic              o_Busy
`ifdef AES_DEC_ABORT_EN
  ,
  input  logic              i_Abort
`endif
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   blk;
  logic [KIDX_W-1:0]   cnt;
  logic [DATA_W-1:0]   dout;
  logic                dout_valid;
  logic                din_ready;
  logic                busy;
  logic [KIDX_W-1:0]   key_idx;
  logic                accept;
  logic                abort_req;
  logic [DATA_W-1:0]   round_out;

`ifdef AES_DEC_ABORT_EN
  assign abort_req = i_Abort;
`else
  assign abort_req = 1'b0;
`endif

  function automatic logic [KIDX_W-1:0] nr_of(input logic [1:0] mode);
    case (mode)
      2'd1:    return KIDX_W'(12);
      2'd2:    return KIDX_W'(14);
      default: return KIDX_W'(10);
    endcase
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n of the block sits at bits [127-8n -: 8]; state column c holds bytes 4c..4c+3.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = INV_SBOX[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    // Row i: 0e*a[i] ^ 0b*a[i+1] ^ 0d*a[i+2] ^ 09*a[i+3]
    for (int i = 0; i < 4; i++) begin
      o[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                     ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                     ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                     ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  assign round_out = inv_shift_sub(blk) ^ i_Round_Key;
  assign accept    = i_Din_Valid && din_ready;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // In IDLE and DONE the key index already points at round key Nr so an accept can whiten.
  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    busy      = 1'b0;
    key_idx   = nr_of(i_Key_Mode);
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (i_Din_Valid) state_nxt = ROUND;
      end
      ROUND: begin
        busy    = 1'b1;
        key_idx = cnt;
        if (abort_req) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        din_ready = i_Dout_Ready;
        if (i_Dout_Ready) state_nxt = i_Din_Valid ? ROUND : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      blk        <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (state == DONE && i_Dout_Ready) dout_valid <= 1'b0;
      if (accept) begin
        blk <= i_Din ^ i_Round_Key;
        cnt <= nr_of(i_Key_Mode) - 1'b1;
      end else if (state == ROUND) begin
        if (abort_req) begin
          cnt <= '0;
        end else if (cnt != '0) begin
          blk <= inv_mix(round_out);
          cnt <= cnt - 1'b1;
        end else begin
          dout       <= round_out;
          dout_valid <= 1'b1;
        end
      end
    end
  end

  assign o_Din_Ready  = din_ready;
  assign o_Busy       = busy;
  assign o_Key_Idx    = key_idx;
  assign o_Dout       = dout;
  assign o_Dout_Valid = dout_valid;

endmodule

`default_nettype wire

// File: tb/tb_aes_dec_round_iter.sv
// tb_aes_dec_round_iter: FIPS-197 vectors against aes_dec_round_iter with a queue scoreboard.
module tb_aes_dec_round_iter;

  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   key_mode;
  logic [127:0] din;
  logic         din_valid;
  logic         din_ready;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic [127:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         busy;
`ifdef AES_DEC_ABORT_EN
  logic         abort;
`endif

  logic [127:0] rk [0:15];
  logic [7:0]   sbox [0:255];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;

  typedef struct {
    logic [127:0] data;
    int           acc;
    int           nr;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key store model: same-cycle return of the requested round key.
  assign round_key = rk[key_idx];

  aes_dec_round_iter dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Key_Mode   (key_mode),
    .i_Din        (din),
    .i_Din_Valid  (din_valid),
    .o_Din_Ready  (din_ready),
    .o_Key_Idx    (key_idx),
    .i_Round_Key  (round_key),
    .o_Dout       (dout),
    .o_Dout_Valid (dout_valid),
    .i_Dout_Ready (dout_ready),
    .o_Busy       (busy)
`ifdef AES_DEC_ABORT_EN
    ,
    .i_Abort      (abort)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from its algebraic definition: GF(2^8) inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Key bytes are 00,01,02,... for every vector; nk = 4/6/8 words.
  task automatic expand(input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [1:0] mode, input logic [127:0] d, input logic [127:0] e, input int nr);
    int   n;
    exp_t item;
    n         = 0;
    key_mode  = mode;
    din       = d;
    din_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (din_ready) break;
      n++;
      if (n > 60) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    item.data = e;
    item.acc  = cyc + 1;
    item.nr   = nr;
    sb.push_back(item);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = ~d;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (dout_valid) break;
      n++;
      if (n > 40) begin
        check("valid_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: first valid cycle of each block pops the scoreboard; every valid cycle checks data.
  logic         checked = 1'b0;
  logic [127:0] cur = '0;
  always @(negedge clk) begin
    exp_t         item;
    logic [127:0] want;
    want = cur;
    if (!rst_n) begin
      checked <= 1'b0;
    end else if (dout_valid) begin
      if (!checked) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          item = sb.pop_front();
          want = item.data;
          cur <= item.data;
          check("latency", 128'(cyc - item.acc), 128'(item.nr));
        end
        checked <= 1'b1;
      end
      check("dout", dout, want);
      check("busy_in_done", busy, 0);
      if (dout_ready) checked <= 1'b0;
    end
  end

  initial begin
    rst_n      = 1'b0;
    key_mode   = 2'd0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
`ifdef AES_DEC_ABORT_EN
    abort      = 1'b0;
`endif
    build_sbox();
    expand(4);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_din_ready", din_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_key_idx", key_idx, 10);
    tick();

    // AES-128, then mode 3 aliasing to AES-128, then AES-192
    send(2'd0, CT128, PT, 10);
    wait_valid();
    send(2'd3, CT128, PT, 10);
    wait_valid();
    expand(6);
    send(2'd1, CT192, PT, 12);
    wait_valid();

    // AES-256 with key-index trace 14..0
    expand(8);
    key_mode = 2'd2;
    @(negedge clk);
    check("idx_idle", key_idx, 14);
    tick();
    send(2'd2, CT256, PT, 14);
    for (int i = 13; i >= 0; i--) begin
      @(negedge clk);
      check("idx_round", key_idx, 128'(i));
      check("busy_round", busy, 1);
    end
    wait_valid();

    // Output backpressure, then back-to-back accept on the release edge
    expand(4);
    dout_ready = 1'b0;
    send(2'd0, CT128, PT, 10);
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      check("hold_din_ready", din_ready, 0);
      check("hold_valid", dout_valid, 1);
    end
    tick();
    dout_ready = 1'b1;
    send(2'd3, CT128, PT, 10);
    check("b2b_busy", busy, 1);
    check("b2b_valid", dout_valid, 0);
    wait_valid();

    // Reset mid-block discards it
    send(2'd0, CT128, PT, 10);
    repeat (5) @(negedge clk);
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout", dout, 0);
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_din_ready", din_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_key_idx", key_idx, 10);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Rerun with mode and din wiggled mid-block
    send(2'd0, CT128, PT, 10);
    repeat (3) tick();
    key_mode = 2'd2;
    din      = CT256;
    repeat (2) tick();
    key_mode = 2'd1;
    wait_valid();
    key_mode = 2'd0;

`ifdef AES_DEC_ABORT_EN
    send(2'd0, CT128, PT, 10);
    repeat (3) @(negedge clk);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_din_ready", din_ready, 1);
    check("abort_valid", dout_valid, 0);
    check("abort_dout", dout, PT);
    sb.delete();
    repeat (12) begin
      @(negedge clk);
      check("abort_no_valid", dout_valid, 0);
    end
    tick();
    send(2'd0, CT128, PT, 10);
    wait_valid();
    dout_ready = 1'b0;
    send(2'd0, CT128, PT, 10);
    wait_valid();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_valid", dout_valid, 1);
    dout_ready = 1'b1;
    tick();
    check("abort_done_clear", dout_valid, 0);
`endif

    repeat (4) tick();
    check("sb_empty", 128'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
